// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// hazard_ctrl_pkg : shared codes, timing encodings and forwarding helper
// Revision 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  // Tuse / Tnew: cycles until an operand is needed / a result is ready
  localparam logic [1:0] T_NOW = 2'd0;
  localparam logic [1:0] T_E   = 2'd1;
  localparam logic [1:0] T_M   = 2'd2;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Youngest ready producer wins; $0 is never forwarded.
  function automatic fwd_sel_e fwd_pick(
    input logic [4:0] src,
    input logic       wr_e, input logic [4:0] a3_e, input logic [1:0] tnew_e,
    input logic       wr_m, input logic [4:0] a3_m, input logic [1:0] tnew_m,
    input logic       wr_w, input logic [4:0] a3_w
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (wr_e && a3_e == src && tnew_e == T_NOW)      sel = FWD_E;
      else if (wr_m && a3_m == src && tnew_m == T_NOW) sel = FWD_M;
      else if (wr_w && a3_w == src)                    sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// hazard_ctrl_if : pipeline <-> hazard controller signal bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
  logic [4:0]  A1D, A2D;
  logic        useRsD, useRtD;
  logic [1:0]  TuseRsD, TuseRtD;
  logic [4:0]  A1E, A2E, A3E;
  logic        RegWriteE;
  logic [1:0]  TnewE;
  logic [4:0]  A2M, A3M;
  logic        RegWriteM;
  logic [1:0]  TnewM;
  logic [4:0]  A3W;
  logic        RegWriteW;
  logic        mdUseD, mdStartE, mdIsDivE;
  logic        stallF, stallD, flushE;
  logic [1:0]  fwdRsD, fwdRtD, fwdRsE, fwdRtE;
  logic        fwdRtM;
  logic        mdBusy, mdErr;
  logic [31:0] stallCnt;

  modport master (
    output A1D, A2D, useRsD, useRtD, TuseRsD, TuseRtD,
           A1E, A2E, A3E, RegWriteE, TnewE,
           A2M, A3M, RegWriteM, TnewM, A3W, RegWriteW,
           mdUseD, mdStartE, mdIsDivE,
    input  stallF, stallD, flushE, fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM,
           mdBusy, mdErr, stallCnt
  );

  modport slave (
    input  A1D, A2D, useRsD, useRtD, TuseRsD, TuseRtD,
           A1E, A2E, A3E, RegWriteE, TnewE,
           A2M, A3M, RegWriteM, TnewM, A3W, RegWriteW,
           mdUseD, mdStartE, mdIsDivE,
    output stallF, stallD, flushE, fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM,
           mdBusy, mdErr, stallCnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// ============================================================================
// hazard_ctrl_md_busy_cnt : mult/div latency counter with sticky overlap error
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl_md_busy_cnt #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic start,
  input  wire logic is_div,
  output logic      busy,
  output logic      err
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      err     <= 1'b0;
    end else begin
      if (start && r_count == '0)
        r_count <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (r_count != '0)
        r_count <= r_count - CNT_W'(1);
      // an overlapping start is dropped; only the flag remembers it
      if (start && r_count != '0)
        err <= 1'b1;
    end
  end

  assign busy = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : Tuse/Tnew stall, flush and forwarding control for 5-stage pipe
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  wire logic   clk,
  input  wire logic   reset,
  hazard_ctrl_if.slave hz
);

  logic w_stall_rs, w_stall_rt, w_stall_md, w_stall;
  logic w_md_busy;
  logic [31:0] r_stall_cnt;

  // a stall is needed only when the producer is still later than the consumer
  assign w_stall_rs = hz.useRsD && (hz.A1D != 5'd0) &&
                      ((hz.RegWriteE && hz.A3E == hz.A1D && hz.TnewE > hz.TuseRsD) ||
                       (hz.RegWriteM && hz.A3M == hz.A1D && hz.TnewM > hz.TuseRsD));
  assign w_stall_rt = hz.useRtD && (hz.A2D != 5'd0) &&
                      ((hz.RegWriteE && hz.A3E == hz.A2D && hz.TnewE > hz.TuseRtD) ||
                       (hz.RegWriteM && hz.A3M == hz.A2D && hz.TnewM > hz.TuseRtD));
  assign w_stall_md = hz.mdUseD && (hz.mdStartE || w_md_busy);
  assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

  assign hz.stallF = w_stall;
  assign hz.stallD = w_stall;
  assign hz.flushE = w_stall;

  assign hz.fwdRsD = fwd_pick(hz.A1D, hz.RegWriteE, hz.A3E, hz.TnewE,
                              hz.RegWriteM, hz.A3M, hz.TnewM, hz.RegWriteW, hz.A3W);
  assign hz.fwdRtD = fwd_pick(hz.A2D, hz.RegWriteE, hz.A3E, hz.TnewE,
                              hz.RegWriteM, hz.A3M, hz.TnewM, hz.RegWriteW, hz.A3W);
  // E stage has no E-to-E path, so the E producer is masked off
  assign hz.fwdRsE = fwd_pick(hz.A1E, 1'b0, 5'd0, T_NOW,
                              hz.RegWriteM, hz.A3M, hz.TnewM, hz.RegWriteW, hz.A3W);
  assign hz.fwdRtE = fwd_pick(hz.A2E, 1'b0, 5'd0, T_NOW,
                              hz.RegWriteM, hz.A3M, hz.TnewM, hz.RegWriteW, hz.A3W);
  assign hz.fwdRtM = hz.RegWriteW && (hz.A3W == hz.A2M) && (hz.A2M != 5'd0);

  hazard_ctrl_md_busy_cnt #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (hz.mdStartE),
    .is_div (hz.mdIsDivE),
    .busy   (w_md_busy),
    .err    (hz.mdErr)
  );

  assign hz.mdBusy = w_md_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (w_stall)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign hz.stallCnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed vectors with hand-computed expectations
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   exp_cnt;
  logic exp_stall;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .MULT_LAT (5),
    .DIV_LAT  (10),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic neutral();
    hz.A1D = 0; hz.A2D = 0; hz.useRsD = 0; hz.useRtD = 0;
    hz.TuseRsD = 0; hz.TuseRtD = 0;
    hz.A1E = 0; hz.A2E = 0; hz.A3E = 0; hz.RegWriteE = 0; hz.TnewE = 0;
    hz.A2M = 0; hz.A3M = 0; hz.RegWriteM = 0; hz.TnewM = 0;
    hz.A3W = 0; hz.RegWriteW = 0;
    hz.mdUseD = 0; hz.mdStartE = 0; hz.mdIsDivE = 0;
  endtask

  // advance one cycle; the bench keeps its own stall-count model
  task automatic tick();
    @(posedge clk);
    if (exp_stall && reset) exp_cnt++;
    @(negedge clk);
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    check_val({tag, "_stallF"}, 32'(hz.stallF), 32'(exp));
    check_val({tag, "_stallD"}, 32'(hz.stallD), 32'(exp));
    check_val({tag, "_flushE"}, 32'(hz.flushE), 32'(exp));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_cnt = 0; exp_stall = 0;
    reset = 1'b0;
    neutral();
    @(negedge clk); #1;
    check_val("rst_cnt", hz.stallCnt, 32'd0);
    check_val("rst_busy", 32'(hz.mdBusy), 32'd0);
    check_val("rst_err", 32'(hz.mdErr), 32'd0);
    chk_stall("rst", 1'b0);
    check_val("rst_fwdRsD", 32'(hz.fwdRsD), 32'd0);
    check_val("rst_fwdRtM", 32'(hz.fwdRtM), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // load-use: lw $8 in E, addu reading $8 in D
    hz.RegWriteE = 1; hz.A3E = 8; hz.TnewE = 2;
    hz.useRsD = 1; hz.A1D = 8; hz.TuseRsD = 1;
    #1; exp_stall = 1;
    chk_stall("lu", 1'b1);
    tick();
    exp_stall = 0;
    hz.RegWriteE = 0; hz.A3E = 0; hz.TnewE = 0;
    hz.RegWriteM = 1; hz.A3M = 8; hz.TnewM = 0;
    hz.A1E = 8;
    #1;
    chk_stall("lu_next", 1'b0);
    check_val("lu_fwdRsD", 32'(hz.fwdRsD), 32'd2);
    check_val("lu_fwdRsE", 32'(hz.fwdRsE), 32'd2);
    check_val("lu_cnt", hz.stallCnt, 32'd1);
    tick();
    check_val("lu_cnt_hold", hz.stallCnt, 32'd1);

    // beq $9 in D needs it in D; addu $9 in M is ready
    neutral();
    hz.RegWriteM = 1; hz.A3M = 9; hz.TnewM = 0;
    hz.useRsD = 1; hz.A1D = 9; hz.TuseRsD = 0;
    #1;
    chk_stall("beq", 1'b0);
    check_val("beq_fwdRsD", 32'(hz.fwdRsD), 32'd2);
    // rt of beq against an E producer not yet ready
    hz.useRtD = 1; hz.A2D = 9; hz.TuseRtD = 0;
    hz.RegWriteE = 1; hz.A3E = 9; hz.TnewE = 1;
    #1; exp_stall = 1;
    chk_stall("rt_e", 1'b1);
    check_val("rt_e_fwdRtD", 32'(hz.fwdRtD), 32'd2);
    tick();
    exp_stall = 0;

    // priority and $0
    neutral();
    hz.RegWriteE = 1; hz.A3E = 5; hz.TnewE = 0;
    hz.RegWriteM = 1; hz.A3M = 5; hz.TnewM = 0;
    hz.RegWriteW = 1; hz.A3W = 5;
    hz.useRsD = 1; hz.A1D = 5; hz.TuseRsD = 1;
    #1;
    check_val("prio_E", 32'(hz.fwdRsD), 32'd1);
    chk_stall("prio", 1'b0);
    hz.A1D = 0; hz.A3E = 0; hz.A3M = 0; hz.A3W = 0; hz.TnewE = 2; hz.TnewM = 2;
    #1;
    check_val("zero_fwd", 32'(hz.fwdRsD), 32'd0);
    chk_stall("zero", 1'b0);
    neutral();
    hz.RegWriteW = 1; hz.A3W = 7; hz.A2D = 7; hz.A2E = 7; hz.A2M = 7;
    #1;
    check_val("w_fwdRtD", 32'(hz.fwdRtD), 32'd3);
    check_val("w_fwdRtE", 32'(hz.fwdRtE), 32'd3);
    check_val("w_fwdRtM", 32'(hz.fwdRtM), 32'd1);
    hz.A3W = 0; hz.A2M = 0;
    #1;
    check_val("w0_fwdRtM", 32'(hz.fwdRtM), 32'd0);
    tick();

    // mult in E, mflo in D: 6 stall cycles, 5 busy
    neutral();
    hz.mdUseD = 1; hz.mdStartE = 1; hz.mdIsDivE = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      exp_stall = (i < 6);
      check_val($sformatf("mult_stall%0d", i), 32'(hz.stallF), 32'(exp_stall));
      check_val($sformatf("mult_busy%0d", i), 32'(hz.mdBusy), 32'((i >= 1) && (i <= 5)));
      tick();
      hz.mdStartE = 0;
    end
    exp_stall = 0;
    check_val("mult_cnt", hz.stallCnt, 32'(exp_cnt));

    // div, then async reset in busy cycle 3
    neutral();
    hz.mdStartE = 1; hz.mdIsDivE = 1;
    tick();
    hz.mdStartE = 0;
    tick(); tick();
    #1;
    check_val("div_busy3", 32'(hz.mdBusy), 32'd1);
    #1; reset = 1'b0; exp_cnt = 0;
    #1;
    check_val("rst_mid_busy", 32'(hz.mdBusy), 32'd0);
    check_val("rst_mid_cnt", hz.stallCnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    hz.mdStartE = 1; hz.mdIsDivE = 1;
    tick();
    hz.mdStartE = 0;
    for (int i = 0; i < 11; i++) begin
      #1;
      check_val($sformatf("div_busy%0d", i), 32'(hz.mdBusy), 32'(i < 10));
      tick();
    end

    // start while busy: ignored, sticky error
    hz.mdStartE = 1; hz.mdIsDivE = 0;
    tick();
    hz.mdStartE = 0;
    tick();
    hz.mdStartE = 1; hz.mdIsDivE = 1;
    #1;
    check_val("ovl_err_pre", 32'(hz.mdErr), 32'd0);
    tick();
    hz.mdStartE = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("ovl_busy%0d", i), 32'(hz.mdBusy), 32'(i < 3));
      check_val($sformatf("ovl_err%0d", i), 32'(hz.mdErr), 32'd1);
      tick();
    end
    check_val("ovl_cnt", hz.stallCnt, 32'(exp_cnt));
    reset = 1'b0;
    #1;
    check_val("ovl_err_rst", 32'(hz.mdErr), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
